// File: rtl/result_display.sv
// rtl/result_display.sv - ALU result to six 7-segment digits via double-dabble BCD conversion
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module result_display #(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       Start,
  input  logic [7:0] Value,
  input  logic       Signed,
  input  logic       Overflow,
  output logic       Busy,
  output logic       Done,
  output logic [7:0] SSegments1,
  output logic [7:0] SSegments2,
  output logic [7:0] SSegments3,
  output logic [7:0] SSegments4,
  output logic [7:0] SSegments5,
  output logic [7:0] SSegments6
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t      state, state_nxt;
  logic [7:0]  raw_q;
  logic        neg_q;
  logic        ovf_q;
  logic [19:0] dd_q;   // {hundreds, tens, units, binary}
  logic [2:0]  cnt_q;
  logic [7:0]  mag;
  logic [3:0]  units, tens, hund;
  logic [7:0]  seg1_d, seg2_d, seg3_d, seg4_d, seg5_d, seg6_d;

  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    logic [7:0] p;
    case (n)
      4'h0: p = 8'hC0;  4'h1: p = 8'hF9;  4'h2: p = 8'hA4;  4'h3: p = 8'hB0;
      4'h4: p = 8'h99;  4'h5: p = 8'h92;  4'h6: p = 8'h82;  4'h7: p = 8'hF8;
      4'h8: p = 8'h80;  4'h9: p = 8'h90;  4'hA: p = 8'h88;  4'hB: p = 8'h83;
      4'hC: p = 8'hC6;  4'hD: p = 8'hA1;  4'hE: p = 8'h86;  default: p = 8'h8E;
    endcase
    return p;
  endfunction

  // Patterns are built active-low; flip them for common-cathode displays.
  function automatic logic [7:0] pol(input logic [7:0] p);
    return (SEG_ACTIVE_LOW != 0) ? p : ~p;
  endfunction

  function automatic logic [19:0] dd_step(input logic [19:0] d);
    logic [19:0] t;
    t = d;
    for (int i = 0; i < 3; i++) begin
      if (t[8+4*i +: 4] >= 4'd5) t[8+4*i +: 4] = t[8+4*i +: 4] + 4'd3;
    end
    return {t[18:0], 1'b0};
  endfunction

  assign mag   = (Signed && Value[7]) ? (~Value + 8'd1) : Value;
  assign units = dd_q[11:8];
  assign tens  = dd_q[15:12];
  assign hund  = dd_q[19:16];

  always_comb begin
    state_nxt = state;
    Busy      = (state != IDLE);
    case (state)
      IDLE:    if (Start) state_nxt = SHIFT;
      SHIFT:   if (cnt_q == 3'd7) state_nxt = UPDATE;
      UPDATE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    seg1_d = hex_seg(units);
    seg2_d = hex_seg(tens);
    seg3_d = hex_seg(hund);
`ifdef LEADING_ZERO_BLANK_EN
    if (hund == 4'd0) begin
      seg3_d = 8'hFF;
      if (tens == 4'd0) seg2_d = 8'hFF;
    end
`else
    seg3_d = hex_seg(hund);
`endif
    seg4_d = neg_q ? 8'hBF : 8'hFF;
    if (ovf_q) seg4_d[7] = 1'b0;
    seg5_d = hex_seg(raw_q[3:0]);
    seg6_d = hex_seg(raw_q[7:4]);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      raw_q      <= 8'd0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      dd_q       <= 20'd0;
      cnt_q      <= 3'd0;
      Done       <= 1'b0;
      SSegments1 <= pol(8'hFF);
      SSegments2 <= pol(8'hFF);
      SSegments3 <= pol(8'hFF);
      SSegments4 <= pol(8'hFF);
      SSegments5 <= pol(8'hFF);
      SSegments6 <= pol(8'hFF);
    end else begin
      state <= state_nxt;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            raw_q <= Value;
            neg_q <= Signed & Value[7];
            ovf_q <= Overflow;
            dd_q  <= {12'd0, mag};
            cnt_q <= 3'd0;
          end
        end
        SHIFT: begin
          dd_q  <= dd_step(dd_q);
          cnt_q <= cnt_q + 3'd1;
        end
        UPDATE: begin
          SSegments1 <= pol(seg1_d);
          SSegments2 <= pol(seg2_d);
          SSegments3 <= pol(seg3_d);
          SSegments4 <= pol(seg4_d);
          SSegments5 <= pol(seg5_d);
          SSegments6 <= pol(seg6_d);
          Done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_display.sv
// tb/tb_result_display.sv - self-checking bench for result_display against an arithmetic reference model
module tb_result_display;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] Value = 8'd0;
  logic       Signed = 1'b0;
  logic       Overflow = 1'b0;
  logic       Busy, Done;
  logic [7:0] SSegments1, SSegments2, SSegments3, SSegments4, SSegments5, SSegments6;

  int tests = 0;
  int fails = 0;
  int n;
  int dones;

  logic [7:0] hex_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  always #5 clock = ~clock;

  result_display dut (
    .clock(clock), .reset(reset), .Start(Start), .Value(Value), .Signed(Signed),
    .Overflow(Overflow), .Busy(Busy), .Done(Done),
    .SSegments1(SSegments1), .SSegments2(SSegments2), .SSegments3(SSegments3),
    .SSegments4(SSegments4), .SSegments5(SSegments5), .SSegments6(SSegments6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input int v, input bit s, input bit o);
    int mag, h, t, u;
    logic [7:0] e1, e2, e3, e4;
    mag = (s && v >= 128) ? 256 - v : v;
    h = mag / 100;
    t = (mag / 10) % 10;
    u = mag % 10;
    e1 = hex_tbl[u];
    e2 = hex_tbl[t];
    e3 = hex_tbl[h];
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) e3 = 8'hFF;
    if (mag < 10) e2 = 8'hFF;
`endif
    e4 = (s && v >= 128) ? 8'hBF : 8'hFF;
    if (o) e4 = e4 & 8'h7F;
    check("seg1_units", {24'd0, SSegments1}, {24'd0, e1});
    check("seg2_tens", {24'd0, SSegments2}, {24'd0, e2});
    check("seg3_hundreds", {24'd0, SSegments3}, {24'd0, e3});
    check("seg4_sign", {24'd0, SSegments4}, {24'd0, e4});
    check("seg5_hex_lo", {24'd0, SSegments5}, {24'd0, hex_tbl[v % 16]});
    check("seg6_hex_hi", {24'd0, SSegments6}, {24'd0, hex_tbl[v / 16]});
  endtask

  task automatic check_blank();
    check("blank1", {24'd0, SSegments1}, 32'hFF);
    check("blank2", {24'd0, SSegments2}, 32'hFF);
    check("blank3", {24'd0, SSegments3}, 32'hFF);
    check("blank4", {24'd0, SSegments4}, 32'hFF);
    check("blank5", {24'd0, SSegments5}, 32'hFF);
    check("blank6", {24'd0, SSegments6}, 32'hFF);
  endtask

  task automatic wait_done(input int n0, output int nout);
    nout = n0;
    while (Done !== 1'b1 && nout < 40) begin
      @(negedge clock);
      nout++;
    end
  endtask

  // One full conversion; inputs are scrambled right after capture.
  task automatic conv(input int v, input bit s, input bit o, input bit rel);
    int k;
    @(negedge clock);
    if (rel) reset = 1'b1;
    Value = v[7:0]; Signed = s; Overflow = o; Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    check("busy_after_capture", {31'd0, Busy}, 32'd1);
    Value = 8'($urandom); Signed = 1'($urandom); Overflow = 1'($urandom);
    wait_done(0, k);
    check("done_latency", k, 9);
    check("busy_at_done", {31'd0, Busy}, 32'd0);
    check_outs(v, s, o);
    @(negedge clock);
    check("done_one_cycle", {31'd0, Done}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_done", {31'd0, Done}, 32'd0);
    check_blank();
    @(negedge clock);
    reset = 1'b1;

    conv(8'hFF, 1'b0, 1'b0, 1'b0);
    conv(8'h80, 1'b1, 1'b1, 1'b0);
    conv(8'h05, 1'b0, 1'b0, 1'b0);
    conv(8'h00, 1'b0, 1'b0, 1'b0);
    conv(8'h7F, 1'b1, 1'b0, 1'b0);
    conv(8'h81, 1'b1, 1'b1, 1'b0);
    conv(8'h63, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++)
      conv(int'($urandom_range(255)), 1'($urandom), 1'($urandom), 1'b0);

    // Start during conversion must be ignored.
    @(negedge clock);
    Value = 8'h10; Signed = 1'b0; Overflow = 1'b0; Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    n = 0;
    repeat (3) begin @(negedge clock); n++; end
    Value = 8'h20; Start = 1'b1;
    @(negedge clock); n++;
    Start = 1'b0;
    wait_done(n, n);
    check("guard_latency", n, 9);
    check_outs(8'h10, 1'b0, 1'b0);
    dones = 0;
    repeat (15) begin @(negedge clock); if (Done === 1'b1) dones++; end
    check("guard_no_second", dones, 0);
    check("guard_idle", {31'd0, Busy}, 32'd0);

    // Start held high restarts right after Done.
    @(negedge clock);
    Value = 8'hC8; Signed = 1'b0; Overflow = 1'b0; Start = 1'b1;
    @(negedge clock);
    wait_done(0, n);
    check("held_first", n, 9);
    check_outs(8'hC8, 1'b0, 1'b0);
    @(negedge clock); n++;
    wait_done(n, n);
    check("held_second", n, 19);
    Start = 1'b0;
    repeat (12) @(negedge clock);

    // Reset in the middle of a conversion.
    @(negedge clock);
    Value = 8'h9A; Signed = 1'b1; Overflow = 1'b1; Start = 1'b1;
    @(negedge clock);
    Start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    check("midreset_done", {31'd0, Done}, 32'd0);
    check_blank();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    dones = 0;
    repeat (12) begin @(negedge clock); if (Done === 1'b1) dones++; end
    check("midreset_no_done", dones, 0);
    check_blank();
    conv(8'hEC, 1'b1, 1'b0, 1'b0);

    // Start coincident with reset release is honoured at the first edge.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    conv(8'h2A, 1'b0, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
